multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_if.sv | 22 ++
 rtl/multicycle_controller.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and status in, control strobes out.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       MemReady;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, AluOp;
  logic [2:0] ImmSrc;
  logic       MemErr, Halted;

  modport master (
    input  opcode, funct3, zero, MemReady,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, AluOp, ImmSrc, MemErr, Halted
  );
  modport slave (
    output opcode, funct3, zero, MemReady,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, AluOp, ImmSrc, MemErr, Halted
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with memory-wait timeout.
// Optional ILLEGAL_HALT_EN: illegal instructions park the FSM in HALT instead of acting as nop.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  multicycle_controller_if.master bus
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam int            CW   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_V = CW'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JALR, JUMP, LUI
`ifdef ILLEGAL_HALT_EN
    , HALT
`endif
  } state_t;

`ifdef ILLEGAL_HALT_EN
  localparam state_t ILLEGAL_ST = HALT;
`else
  localparam state_t ILLEGAL_ST = FETCH;
`endif

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          wait_st, timeout;
  logic          pcw, irw, rw, mw, adr, merr, halted;
  logic [1:0]    sa, sb, rs, aop;
  logic [2:0]    imm;

  assign wait_st = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  assign timeout = (MEM_TIMEOUT != 0) && wait_st && !bus.MemReady && (cnt == TO_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_n;
      // counter only tracks an unbroken stall within one wait state
      if (!wait_st || bus.MemReady || timeout || (state_n != state)) cnt <= '0;
      else                                                          cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_n = state;
    pcw = 1'b0; irw = 1'b0; rw = 1'b0; mw = 1'b0; adr = 1'b0;
    merr = 1'b0; halted = 1'b0;
    sa = 2'b00; sb = 2'b00; rs = 2'b00; aop = 2'b00;
    case (bus.opcode)
      OP_STORE: imm = 3'b001;
      OP_BR:    imm = 3'b010;
      OP_LUI:   imm = 3'b011;
      OP_JAL:   imm = 3'b100;
      default:  imm = 3'b000;
    endcase
    case (state)
      FETCH: begin
        sb = 2'b10; rs = 2'b10;
        pcw = bus.MemReady; irw = bus.MemReady;
        if (bus.MemReady) state_n = DECODE;
      end
      DECODE: begin
        sa = 2'b01; sb = 2'b01;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_n = MEMADR;
          OP_R:              state_n = EXECR;
          OP_I:              state_n = EXECI;
          OP_BR:             state_n = BRANCH;
          OP_JALR:           state_n = JALR;
          OP_JAL:            state_n = JUMP;
          OP_LUI:            state_n = LUI;
          default:           state_n = ILLEGAL_ST;
        endcase
      end
      MEMADR: begin
        sa = 2'b10; sb = 2'b01;
        state_n = (bus.opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr = 1'b1;
        if (bus.MemReady) state_n = MEMWB;
      end
      MEMWB: begin
        rs = 2'b01; rw = 1'b1; state_n = FETCH;
      end
      MEMWRITE: begin
        adr = 1'b1; mw = 1'b1;
        if (bus.MemReady) state_n = FETCH;
      end
      EXECR: begin
        sa = 2'b10; aop = 2'b10; state_n = ALUWB;
      end
      EXECI: begin
        sa = 2'b10; sb = 2'b01; aop = 2'b10; state_n = ALUWB;
      end
      ALUWB: begin
        rw = 1'b1; state_n = FETCH;
      end
      BRANCH: begin
        sa = 2'b10; aop = 2'b01; state_n = FETCH;
        case (bus.funct3)
          3'b000:  pcw = bus.zero;
          3'b001:  pcw = !bus.zero;
          default: state_n = ILLEGAL_ST;
        endcase
      end
      JALR: begin
        sa = 2'b10; sb = 2'b01; state_n = JUMP;
      end
      // JUMP loads the target into PC while ALU forms OldPC+4 for the link write
      JUMP: begin
        sa = 2'b01; sb = 2'b10; pcw = 1'b1; state_n = ALUWB;
      end
      LUI: begin
        rs = 2'b11; rw = 1'b1; state_n = FETCH;
      end
`ifdef ILLEGAL_HALT_EN
      HALT: begin
        halted = 1'b1; state_n = HALT;
      end
`endif
      default: state_n = FETCH;
    endcase
    if (timeout) begin
      merr = 1'b1; pcw = 1'b0; irw = 1'b0; rw = 1'b0; mw = 1'b0;
      state_n = FETCH;
    end
    if (rst) begin
      pcw = 1'b0; irw = 1'b0; rw = 1'b0; mw = 1'b0;
    end
  end

  assign bus.PCWrite   = pcw;
  assign bus.IRWrite   = irw;
  assign bus.RegWrite  = rw;
  assign bus.MemWrite  = mw;
  assign bus.AdrSrc    = adr;
  assign bus.ALUSrcA   = sa;
  assign bus.ALUSrcB   = sb;
  assign bus.ResultSrc = rs;
  assign bus.AluOp     = aop;
  assign bus.ImmSrc    = imm;
  assign bus.MemErr    = merr;
  assign bus.Halted    = halted;
endmodule
